// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes and FSM encoding.
package mdu_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per step.
// quotient/remainder show the values the registers take if this cycle steps.
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quo_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] dsr_reg;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] rem_next;

    // The partial remainder is always below the divisor, so a failed trial fits in XLEN bits.
    assign trial    = {rem_reg, quo_reg[XLEN-1]};
    assign diff     = trial - {1'b0, dsr_reg};
    assign fits     = ~diff[XLEN];
    assign rem_next = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_next = {quo_reg[XLEN-2:0], fits};

    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_reg <= '0;
            rem_reg <= '0;
            dsr_reg <= '0;
        end else if (load) begin
            quo_reg <= dividend;
            rem_reg <= '0;
            dsr_reg <= divisor;
        end else if (step) begin
            quo_reg <= quo_next;
            rem_reg <= rem_next;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit at the EX end of ID/EX; stalls upstream until done.
// Define MDU_FAST_MUL_EN for single-cycle MUL* ops (DIV/REM stay iterative).
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        funct3_reg;
    logic              neg_reg;
    logic [XLEN-1:0]   mcand_reg;
    logic [2*XLEN-1:0] prod_reg;
    logic [XLEN-1:0]   result_reg;
    logic              result_valid_reg;

    logic              a_signed, b_signed, a_neg, b_neg, neg_next;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [XLEN-1:0]   quotient, remainder, mul_res, div_res;

    function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] p,
                                                input logic neg, input logic [2:0] f);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        case (f)
            MULH, MULHSU, MULHU: mul_fix = s[2*XLEN-1:XLEN];
            default:             mul_fix = s[XLEN-1:0];
        endcase
    endfunction

    // Operate on magnitudes; the recorded sign is applied once at the end.
    assign a_signed = (funct3 != MULHU) && (funct3 != DIVU) && (funct3 != REMU);
    assign b_signed = a_signed && (funct3 != MULHSU);
    assign a_neg    = a_signed & op_a[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign neg_next = (funct3 == REM) ? a_neg : (a_neg ^ b_neg);

    assign div_zero    = (op_b == '0);
    assign div_ovf     = ((funct3 == DIV) || (funct3 == REM)) && (op_a == INT_MIN) && (op_b == '1);
    assign special     = funct3[2] && (div_zero || div_ovf);
    assign special_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : INT_MIN);

    // Shift-add multiply: the multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    assign prod_step = {mul_sum, prod_reg[XLEN-1:1]};
    assign mul_res   = mul_fix(prod_step, neg_reg, funct3_reg);
    assign div_res   = funct3_reg[1] ? (neg_reg ? -remainder : remainder)
                                     : (neg_reg ? -quotient  : quotient);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    mdu_divider #(.XLEN(XLEN)) u_divider (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_reg == IDLE) && start),
        .step     ((state_reg == BUSY) && funct3_reg[2]),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (quotient),
        .remainder(remainder)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            funct3_reg       <= '0;
            neg_reg          <= 1'b0;
            mcand_reg        <= '0;
            prod_reg         <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            if (kill) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: if (start) begin
                        funct3_reg <= funct3;
                        neg_reg    <= neg_next;
                        mcand_reg  <= a_mag;
                        prod_reg   <= {{XLEN{1'b0}}, b_mag};
                        cnt_reg    <= '0;
                        if (special) begin
                            state_reg        <= DONE;
                            result_valid_reg <= 1'b1;
                            result_reg       <= special_res;
`ifdef MDU_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            state_reg        <= DONE;
                            result_valid_reg <= 1'b1;
                            result_reg       <= mul_fix(fast_prod, neg_next, funct3);
`endif
                        end else begin
                            state_reg <= BUSY;
                        end
                    end
                    BUSY: begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (!funct3_reg[2]) prod_reg <= prod_step;
                        if (cnt_reg == LAST_CNT) begin
                            state_reg        <= DONE;
                            result_valid_reg <= 1'b1;
                            result_reg       <= funct3_reg[2] ? div_res : mul_res;
                        end
                    end
                    // start still shows the finished instruction here, so it is ignored.
                    DONE:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign busy         = (state_reg == BUSY);
    assign stall        = ((state_reg == IDLE) && start && !kill) || (state_reg == BUSY);
    assign result_valid = result_valid_reg;
    assign result       = result_reg;

endmodule
